mips_memwb_stage: RTL and testbench
===================================

Name: mips_memwb_stage

Overview:
- MEM/WB pipeline stage of the 5-stage MIPS core; sits directly upstream of the 32x32 byte-writable register file.
- Captures the MEM-stage result and aligns/extends load data, including LWL/LWR.
- Drives the register file write port (dadd, data, wen, byte enables wen_4..wen_1) from registered outputs.
- Also flags misaligned loads and counts retired instructions.

Parameters:
- BIG_ENDIAN, 1, byte-lane order of m_rdata; 1 = MIPS big-endian (offset 0 = bits 31:24), 0 = little-endian (offset 0 = bits 7:0)
- CNT_W, 32, width of retire counter

Ports:
- clk  in  1  clock, rising edge
- rst_n  in  1  asynchronous active-low reset
- m_valid  in  1  MEM stage holds a real instruction
- m_regwrite  in  1  instruction writes a GPR
- m_rd  in  5  destination register
- m_ldop  in  3  load type (package enum)
- m_alu  in  32  ALU result / effective address
- m_rdata  in  32  aligned word read from data memory
- stall  in  1  MEM not advancing this cycle
- flush  in  1  kill instruction in MEM
- dadd  out  5  register file write address
- data  out  32  register file write data
- wen  out  1  register file write enable
- wen_4  out  1  byte enable, bits 31:24
- wen_3  out  1  byte enable, bits 23:16
- wen_2  out  1  byte enable, bits 15:8
- wen_1  out  1  byte enable, bits 7:0
- adel  out  1  one-cycle pulse: misaligned load suppressed
- retire_cnt  out  CNT_W  instructions retired

Behaviour:
- Reset: asynchronous on rst_n=0. dadd=0, data=0, wen=0, wen_4..wen_1=0, adel=0, retire_cnt=0. Reset mid-operation discards the in-flight instruction; no partial write.
- Latency: 1 cycle. Inputs sampled at posedge N appear on outputs after N. The register file commits them at posedge N+1.
- Advance condition: adv = m_valid & ~stall & ~flush.
  - adv=0 (stall, flush, or both) loads a bubble: wen=0, all wen_x=0, adel=0. dadd/data hold their previous values.
  - Outputs are never held across a stall, so no double write and no double count.
- Offset: off = m_alu[1:0]. Byte lane b(off): BIG_ENDIAN=1 gives bits [31-8*off -: 8]; BIG_ENDIAN=0 gives bits [8*off +: 8].
- Load handling by m_ldop:
  - LD_NONE: data=m_alu, all four byte enables set.
  - LB / LBU: byte b(off), sign- or zero-extended to 32 bits, all enables set.
  - LH / LHU: halfword at off (off must be 0 or 2), sign- or zero-extended, all enables set.
  - LW: off must be 0, data=m_rdata, all enables set.
  - LWL (BE): data = m_rdata << 8*off; enables {4} through lane 4-off. off=0 → 1111, 1 → 1110, 2 → 1100, 3 → 1000 (order wen_4..wen_1).
  - LWR (BE): data = m_rdata >> 8*(3-off). off=3 → 1111, 2 → 0111, 1 → 0011, 0 → 0001.
  - LWL/LWR with BIG_ENDIAN=0: mirror image of the above.
  - Reserved encodings are treated as LD_NONE.
- wen = adv & m_regwrite & (m_rd≠0) & ~misaligned. When wen=0, all wen_x=0.
- Misaligned: LH/LHU with off[0]=1, or LW with off≠0. On adv: write suppressed, adel=1 for one cycle, instruction still counted as retired.
- retire_cnt: +1 on each adv, wraps modulo 2^CNT_W. Writes to r0 and stores (m_regwrite=0) also count.
- Simultaneous stall and flush: bubble, no count.

Decomposition:
- Package mips_pkg:
  - ld_op_t enum: LD_NONE=0, LD_LB=1, LD_LBU=2, LD_LH=3, LD_LHU=4, LD_LW=5, LD_LWL=6, LD_LWR=7
  - BE_ALL = 4'b1111
- Sub-module mips_load_align: purely combinational; inputs m_ldop, off, m_rdata, m_alu; outputs aligned data, 4-bit byte mask, misaligned flag.
- The stage itself holds the pipeline register, bubble logic, adel pulse and counter.

Test Plan:
- LB, BE, rdata=0x12F45678, off=1, rd=5, adv → next cycle dadd=5, data=0xFFFFFFF4, wen=1, wen_4..1=1111; LBU same → data=0x000000F4.
- LWL off=2, rdata=0xAABBCCDD → data=0xCCDD0000, enables 1100; LWR off=1 → data=0x0000AABB, enables 0011; LWL off=0 / LWR off=3 → full word, 1111.
- LW off=2, rd=7 → wen=0, enables 0000, adel pulses 1 cycle, retire_cnt +1; LH off=1 → same.
- stall=1 for 3 cycles with valid ALU op rd=3 → wen=0 each cycle, retire_cnt unchanged; release → single write, data=m_alu, count +1. stall=flush=1 → bubble.
- m_rd=0 with regwrite → wen=0, count +1. Counter preloaded to 2^CNT_W−1 via adv sequence → wraps to 0.
- rst_n asserted asynchronously mid-cycle while wen=1 → all outputs 0 immediately; first adv after release produces a correct write.

Source files
------------

// File: rtl/mips_pkg.sv
// Shared types and constants for the MIPS core pipeline.
package mips_pkg;

    localparam int unsigned WORD_W = 32;
    localparam int unsigned REG_AW = 5;
    localparam int unsigned BE_W   = 4;

    typedef enum logic [2:0] {
        LD_NONE = 3'd0,
        LD_LB   = 3'd1,
        LD_LBU  = 3'd2,
        LD_LH   = 3'd3,
        LD_LHU  = 3'd4,
        LD_LW   = 3'd5,
        LD_LWL  = 3'd6,
        LD_LWR  = 3'd7
    } ld_op_t;

    localparam logic [BE_W-1:0] BE_ALL = 4'b1111;

endpackage

// File: rtl/mips_load_align.sv
// Load data alignment/extension, byte-lane mask and misalignment detect.
module mips_load_align
    import mips_pkg::*;
#(
    parameter bit BIG_ENDIAN = 1'b1
) (
    input  ld_op_t              m_ldop,
    input  logic [1:0]          off,
    input  logic [WORD_W-1:0]   m_rdata,
    input  logic [WORD_W-1:0]   m_alu,
    output logic [WORD_W-1:0]   data_c,
    output logic [BE_W-1:0]     mask_c,
    output logic                misaligned_c
);

    logic [1:0]  lane;
    logic [7:0]  byte_v;
    logic        hsel;
    logic [15:0] half_v;
    logic [1:0]  sh_l;
    logic [1:0]  sh_r;

    // Memory offset to physical lane; LWL/LWR shift amounts swap with endianness.
    always_comb begin
        lane   = BIG_ENDIAN ? 2'(2'd3 - off) : off;
        byte_v = m_rdata[8*lane +: 8];
        hsel   = BIG_ENDIAN ? ~off[1] : off[1];
        half_v = hsel ? m_rdata[31:16] : m_rdata[15:0];
        sh_l   = BIG_ENDIAN ? off : 2'(2'd3 - off);
        sh_r   = BIG_ENDIAN ? 2'(2'd3 - off) : off;
    end

    always_comb begin
        data_c       = m_alu;
        mask_c       = BE_ALL;
        misaligned_c = 1'b0;
        case (m_ldop)
            LD_LB:   data_c = {{24{byte_v[7]}}, byte_v};
            LD_LBU:  data_c = {24'd0, byte_v};
            LD_LH: begin
                data_c       = {{16{half_v[15]}}, half_v};
                misaligned_c = off[0];
            end
            LD_LHU: begin
                data_c       = {16'd0, half_v};
                misaligned_c = off[0];
            end
            LD_LW: begin
                data_c       = m_rdata;
                misaligned_c = (off != 2'd0);
            end
            LD_LWL: begin
                data_c = m_rdata << {sh_l, 3'b000};
                mask_c = BE_ALL << sh_l;
            end
            LD_LWR: begin
                data_c = m_rdata >> {sh_r, 3'b000};
                mask_c = BE_ALL >> sh_r;
            end
            default: begin
                data_c       = m_alu;
                mask_c       = BE_ALL;
                misaligned_c = 1'b0;
            end
        endcase
    end

endmodule

// File: rtl/mips_memwb_stage.sv
// MEM/WB pipeline register: register file write port, misaligned-load flag
// and retired-instruction counter.
module mips_memwb_stage
    import mips_pkg::*;
#(
    parameter bit          BIG_ENDIAN = 1'b1,
    parameter int unsigned CNT_W      = 32
) (
    input  logic                clk,
    input  logic                rst_n,
    input  logic                m_valid,
    input  logic                m_regwrite,
    input  logic [REG_AW-1:0]   m_rd,
    input  logic [2:0]          m_ldop,
    input  logic [WORD_W-1:0]   m_alu,
    input  logic [WORD_W-1:0]   m_rdata,
    input  logic                stall,
    input  logic                flush,
    output logic [REG_AW-1:0]   dadd,
    output logic [WORD_W-1:0]   data,
    output logic                wen,
    output logic                wen_4,
    output logic                wen_3,
    output logic                wen_2,
    output logic                wen_1,
    output logic                adel,
    output logic [CNT_W-1:0]    retire_cnt
);

    logic [WORD_W-1:0] al_data_c;
    logic [BE_W-1:0]   al_mask_c;
    logic              al_mis_c;
    logic              adv_c;
    logic              wen_nxt_c;

    mips_load_align #(
        .BIG_ENDIAN(BIG_ENDIAN)
    ) u_align (
        .m_ldop       (ld_op_t'(m_ldop)),
        .off          (m_alu[1:0]),
        .m_rdata      (m_rdata),
        .m_alu        (m_alu),
        .data_c       (al_data_c),
        .mask_c       (al_mask_c),
        .misaligned_c (al_mis_c)
    );

    assign adv_c     = m_valid & ~stall & ~flush;
    assign wen_nxt_c = adv_c & m_regwrite & (m_rd != '0) & ~al_mis_c;

    // Enables are rebuilt every cycle so a stalled instruction never writes twice.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            dadd       <= '0;
            data       <= '0;
            wen        <= 1'b0;
            wen_4      <= 1'b0;
            wen_3      <= 1'b0;
            wen_2      <= 1'b0;
            wen_1      <= 1'b0;
            adel       <= 1'b0;
            retire_cnt <= '0;
        end else begin
            wen                          <= wen_nxt_c;
            {wen_4, wen_3, wen_2, wen_1} <= wen_nxt_c ? al_mask_c : 4'b0000;
            adel                         <= adv_c & al_mis_c;
            if (adv_c) begin
                dadd       <= m_rd;
                data       <= al_data_c;
                retire_cnt <= retire_cnt + CNT_W'(1);
            end
        end
    end

endmodule

// File: tb/tb_mips_memwb_stage.sv
// Randomized + directed bench for the MEM/WB stage against a byte-level model.
module tb_mips_memwb_stage;
    import mips_pkg::*;

    localparam bit          BIG_ENDIAN = 1'b1;
    localparam int unsigned CNT_W      = 8;

    logic              clk;
    logic              rst_n;
    logic              m_valid;
    logic              m_regwrite;
    logic [4:0]        m_rd;
    logic [2:0]        m_ldop;
    logic [31:0]       m_alu;
    logic [31:0]       m_rdata;
    logic              stall;
    logic              flush;
    logic [4:0]        dadd;
    logic [31:0]       data;
    logic              wen;
    logic              wen_4, wen_3, wen_2, wen_1;
    logic              adel;
    logic [CNT_W-1:0]  retire_cnt;

    int checks   = 0;
    int failures = 0;

    logic [4:0]        e_dadd;
    logic [31:0]       e_data;
    logic              e_wen;
    logic [3:0]        e_mask;
    logic              e_adel;
    logic [CNT_W-1:0]  e_cnt;
    bit                data_known;

    mips_memwb_stage #(
        .BIG_ENDIAN(BIG_ENDIAN),
        .CNT_W     (CNT_W)
    ) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .m_valid    (m_valid),
        .m_regwrite (m_regwrite),
        .m_rd       (m_rd),
        .m_ldop     (m_ldop),
        .m_alu      (m_alu),
        .m_rdata    (m_rdata),
        .stall      (stall),
        .flush      (flush),
        .dadd       (dadd),
        .data       (data),
        .wen        (wen),
        .wen_4      (wen_4),
        .wen_3      (wen_3),
        .wen_2      (wen_2),
        .wen_1      (wen_1),
        .adel       (adel),
        .retire_cnt (retire_cnt)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
        end
    endtask

    // Memory byte k holds the k-th byte in address order; register lanes are numbered from the LSB.
    function automatic void model_align(input logic [2:0] op, input logic [1:0] off,
                                        input logic [31:0] rdata, input logic [31:0] alu,
                                        output logic [31:0] d, output logic [3:0] mk,
                                        output bit mis);
        logic [7:0]  mb [4];
        logic [15:0] hw;
        int o, k;
        o = int'(off);
        for (int i = 0; i < 4; i++)
            mb[i] = BIG_ENDIAN ? 8'(rdata >> (8 * (3 - i))) : 8'(rdata >> (8 * i));
        d = alu; mk = 4'hF; mis = 1'b0;
        case (op)
            3'd1, 3'd2: begin
                d = 32'(mb[o]);
                if (op == 3'd1 && mb[o][7]) d = d | 32'hFFFF_FF00;
            end
            3'd3, 3'd4: begin
                mis = off[0];
                if (!mis) begin
                    hw = BIG_ENDIAN ? {mb[o], mb[o+1]} : {mb[o+1], mb[o]};
                    d  = 32'(hw);
                    if (op == 3'd3 && hw[15]) d = d | 32'hFFFF_0000;
                end
            end
            3'd5: begin
                mis = (off != 2'd0);
                d   = rdata;
            end
            3'd6, 3'd7: begin
                d = 32'd0; mk = 4'h0;
                for (int lane = 0; lane < 4; lane++) begin
                    if (op == 3'd6) k = BIG_ENDIAN ? o + (3 - lane) : o - (3 - lane);
                    else            k = BIG_ENDIAN ? o - lane : o + lane;
                    if (k >= 0 && k <= 3) begin
                        d[8*lane +: 8] = mb[k];
                        mk[lane]       = 1'b1;
                    end
                end
            end
            default: ;
        endcase
    endfunction

    task automatic model_reset();
        e_dadd = '0; e_data = '0; e_wen = 1'b0; e_mask = '0; e_adel = 1'b0;
        e_cnt = '0; data_known = 1'b1;
    endtask

    task automatic model_update();
        logic [31:0] d;
        logic [3:0]  mk;
        bit          mis, adv, w;
        adv = m_valid && !stall && !flush;
        model_align(m_ldop, m_alu[1:0], m_rdata, m_alu, d, mk, mis);
        w = adv && m_regwrite && (m_rd != 5'd0) && !mis;
        e_wen  = w;
        e_mask = w ? mk : 4'h0;
        e_adel = adv && mis;
        if (adv) begin
            e_dadd     = m_rd;
            e_data     = d;
            data_known = !mis;
            e_cnt      = e_cnt + 1'b1;
        end
    endtask

    task automatic compare_all();
        check("wen", 32'(wen), 32'(e_wen));
        check("byte_en", 32'({wen_4, wen_3, wen_2, wen_1}), 32'(e_mask));
        check("adel", 32'(adel), 32'(e_adel));
        check("retire_cnt", 32'(retire_cnt), 32'(e_cnt));
        check("dadd", 32'(dadd), 32'(e_dadd));
        if (data_known) check("data", data, e_data);
    endtask

    task automatic drive(input logic v, input logic rw, input logic [4:0] rd, input logic [2:0] op,
                         input logic [31:0] alu, input logic [31:0] rdata,
                         input logic st, input logic fl);
        m_valid = v; m_regwrite = rw; m_rd = rd; m_ldop = op;
        m_alu = alu; m_rdata = rdata; stall = st; flush = fl;
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
        model_update();
        compare_all();
    endtask

    task automatic load(input logic [2:0] op, input logic [31:0] alu, input logic [31:0] rdata,
                        input logic [4:0] rd);
        drive(1'b1, 1'b1, rd, op, alu, rdata, 1'b0, 1'b0);
        tick();
    endtask

    logic [CNT_W-1:0] cnt0;

    initial begin
        rst_n = 1'b0;
        drive(1'b0, 1'b0, 5'd0, LD_NONE, 32'd0, 32'd0, 1'b0, 1'b0);
        model_reset();
        repeat (2) @(posedge clk);
        #1;
        check("rst_wen", 32'(wen), 32'd0);
        check("rst_data", data, 32'd0);
        check("rst_cnt", 32'(retire_cnt), 32'd0);
        compare_all();
        @(negedge clk);
        rst_n = 1'b1;

        // Byte loads
        load(LD_LB, 32'h0000_1001, 32'h12F4_5678, 5'd5);
        check("lb_data", data, 32'hFFFF_FFF4);
        check("lb_dadd", 32'(dadd), 32'd5);
        check("lb_be", 32'({wen_4, wen_3, wen_2, wen_1}), 32'hF);
        load(LD_LBU, 32'h0000_1001, 32'h12F4_5678, 5'd5);
        check("lbu_data", data, 32'h0000_00F4);

        // Unaligned word halves
        load(LD_LWL, 32'h0000_2002, 32'hAABB_CCDD, 5'd6);
        check("lwl2_data", data, 32'hCCDD_0000);
        check("lwl2_be", 32'({wen_4, wen_3, wen_2, wen_1}), 32'hC);
        load(LD_LWR, 32'h0000_2001, 32'hAABB_CCDD, 5'd6);
        check("lwr1_data", data, 32'h0000_AABB);
        check("lwr1_be", 32'({wen_4, wen_3, wen_2, wen_1}), 32'h3);
        load(LD_LWL, 32'h0000_2000, 32'hAABB_CCDD, 5'd6);
        check("lwl0_data", data, 32'hAABB_CCDD);
        check("lwl0_be", 32'({wen_4, wen_3, wen_2, wen_1}), 32'hF);
        load(LD_LWR, 32'h0000_2003, 32'hAABB_CCDD, 5'd6);
        check("lwr3_data", data, 32'hAABB_CCDD);
        check("lwr3_be", 32'({wen_4, wen_3, wen_2, wen_1}), 32'hF);

        // Misaligned loads
        cnt0 = retire_cnt;
        load(LD_LW, 32'h0000_3002, 32'h1234_5678, 5'd7);
        check("lw_mis_wen", 32'(wen), 32'd0);
        check("lw_mis_adel", 32'(adel), 32'd1);
        check("lw_mis_cnt", 32'(retire_cnt), 32'(CNT_W'(cnt0 + 1'b1)));
        load(LD_LH, 32'h0000_3001, 32'h1234_5678, 5'd7);
        check("lh_mis_adel", 32'(adel), 32'd1);
        load(LD_NONE, 32'h0000_0044, 32'd0, 5'd8);
        check("adel_pulse", 32'(adel), 32'd0);

        // Stall then release
        cnt0 = retire_cnt;
        drive(1'b1, 1'b1, 5'd3, LD_NONE, 32'hCAFE_0001, 32'd0, 1'b1, 1'b0);
        repeat (3) begin
            tick();
            check("stall_wen", 32'(wen), 32'd0);
            check("stall_cnt", 32'(retire_cnt), 32'(cnt0));
        end
        stall = 1'b0;
        tick();
        check("rel_wen", 32'(wen), 32'd1);
        check("rel_data", data, 32'hCAFE_0001);
        check("rel_cnt", 32'(retire_cnt), 32'(CNT_W'(cnt0 + 1'b1)));
        tick();
        drive(1'b1, 1'b1, 5'd3, LD_NONE, 32'h5, 32'd0, 1'b1, 1'b1);
        tick();
        check("stflush_wen", 32'(wen), 32'd0);

        // r0 destination still retires
        cnt0 = retire_cnt;
        load(LD_NONE, 32'h0000_0099, 32'd0, 5'd0);
        check("r0_wen", 32'(wen), 32'd0);
        check("r0_cnt", 32'(retire_cnt), 32'(CNT_W'(cnt0 + 1'b1)));

        // Asynchronous reset mid-cycle while a write is presented
        load(LD_NONE, 32'h0000_0077, 32'd0, 5'd9);
        check("pre_rst_wen", 32'(wen), 32'd1);
        #2 rst_n = 1'b0;
        #1;
        check("arst_wen", 32'(wen), 32'd0);
        check("arst_be", 32'({wen_4, wen_3, wen_2, wen_1}), 32'd0);
        check("arst_dadd", 32'(dadd), 32'd0);
        check("arst_data", data, 32'd0);
        check("arst_cnt", 32'(retire_cnt), 32'd0);
        model_reset();
        @(negedge clk);
        rst_n = 1'b1;
        load(LD_LBU, 32'h0000_0002, 32'h1122_3344, 5'd10);
        check("post_rst_data", data, 32'h0000_0033);
        check("post_rst_cnt", 32'(retire_cnt), 32'd1);

        // Counter wrap
        drive(1'b1, 1'b0, 5'd1, LD_NONE, 32'd0, 32'd0, 1'b0, 1'b0);
        repeat (254) tick();
        check("cnt_max", 32'(retire_cnt), 32'hFF);
        tick();
        check("cnt_wrap", 32'(retire_cnt), 32'd0);

        // Randomized traffic
        repeat (600) begin
            drive(($urandom_range(0, 9) < 8), ($urandom_range(0, 9) < 8),
                  ($urandom_range(0, 7) == 0) ? 5'd0 : 5'($urandom),
                  3'($urandom), $urandom, $urandom,
                  ($urandom_range(0, 4) == 0), ($urandom_range(0, 9) == 0));
            tick();
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
